// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 fetch definitions: icode values, status and
//               FSM encodings, instruction length and register-byte helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT_PC = 2'd2,
    S_HALTED  = 2'd3
  } fsm_state_t;

  // Encoded instruction length in bytes; unknown opcodes count as one byte.
  function automatic logic [3:0] ilen(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                 ilen = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     ilen = 4'd2;
      I_JXX, I_CALL:                        ilen = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         ilen = 4'd10;
      default:                              ilen = 4'd1;
    endcase
  endfunction

  // True when byte 1 of the instruction carries rA/rB.
  function automatic logic has_regids(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ:               has_regids = 1'b1;
      default:                              has_regids = 1'b0;
    endcase
  endfunction

  // Control-flow instructions whose successor PC comes from later stages.
  function automatic logic is_ctrl(input logic [3:0] icode);
    is_ctrl = (icode == I_JXX) || (icode == I_CALL) || (icode == I_RET);
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : y86_fetch_unit_if
// Description : Bus bundle of the fetch stage: instruction-memory load port,
//               control strobes and the fetched-slot valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface y86_fetch_unit_if
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 2048,
  parameter int PC_W       = 64
);
  localparam int AW = $clog2(IMEM_BYTES);

  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [7:0]      imem_wdata;
  logic            start;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      icode;
  logic [3:0]      ifun;
  logic [3:0]      rA;
  logic [3:0]      rB;
  logic [PC_W-1:0] valC;
  logic [PC_W-1:0] valP;
  logic [PC_W-1:0] pc_out;
  stat_t           stat;
  logic [1:0]      state_o;

  // Environment side (loader, execute/writeback, decode)
  modport master (
    output imem_we, imem_waddr, imem_wdata, start, pc_load, pc_load_val, out_ready,
    input  out_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat, state_o
  );

  // Fetch-unit side
  modport slave (
    input  imem_we, imem_waddr, imem_wdata, start, pc_load, pc_load_val, out_ready,
    output out_valid, icode, ifun, rA, rB, valC, valP, pc_out, stat, state_o
  );

endinterface
`default_nettype wire

// File: rtl/y86_imem.sv
`default_nettype none
// ============================================================================
// Module      : y86_imem
// Description : Byte-addressed instruction memory with a synchronous byte
//               write port and a combinational 10-byte read window at rpc.
//               Bytes outside the array read as 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_imem #(
  parameter int IMEM_BYTES = 2048,
  parameter int PC_W       = 64,
  parameter int AW         = $clog2(IMEM_BYTES)
) (
  input  wire logic            clk,
  input  wire logic            we,
  input  wire logic [AW-1:0]   waddr,
  input  wire logic [7:0]      wdata,
  input  wire logic [PC_W-1:0] rpc,
  output logic      [79:0]     window
);

  // One extra bit so rpc+i never wraps before the range test.
  localparam logic [PC_W:0] c_lim = (PC_W+1)'(IMEM_BYTES);

  logic [7:0] r_mem [IMEM_BYTES];

  // Byte store; contents survive reset
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  for (genvar i = 0; i < 10; i++) begin : g_rd
    logic [PC_W:0] w_addr;
    assign w_addr          = {1'b0, rpc} + (PC_W+1)'(i);
    assign window[8*i +: 8] = (w_addr < c_lim) ? r_mem[w_addr[AW-1:0]] : 8'h00;
  end

endmodule
`default_nettype wire

// File: rtl/y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : y86_fetch_unit
// Description : Y86-64 SEQ fetch stage. Owns the PC and instruction memory,
//               splits each instruction into icode/ifun/rA/rB/valC, computes
//               valP and presents one slot at a time over valid/ready.
//               Stalls after jXX/call/ret until the PC is reloaded; stops for
//               good on HLT/ADR/INS.
//               Optional macro FETCH_STATS_EN adds fetch_count/stall_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int              IMEM_BYTES = 2048,
  parameter int              PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  y86_fetch_unit_if.slave   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int            AW    = $clog2(IMEM_BYTES);
  localparam logic [PC_W:0] c_lim = (PC_W+1)'(IMEM_BYTES);

  fsm_state_t      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic            w_load_slot;

  logic [79:0]     w_win;
  logic [3:0]      w_icode, w_ifun, w_len;
  logic            w_regids, w_ins, w_adr;
  logic [63:0]     w_valc64;
  logic [PC_W-1:0] w_valp;
  logic [PC_W:0]   w_end;
  stat_t           w_stat;

  logic            r_out_valid;
  logic [3:0]      r_icode, r_ifun, r_ra, r_rb;
  logic [PC_W-1:0] r_valc, r_valp, r_pc_out;
  stat_t           r_stat;

  y86_imem #(
    .IMEM_BYTES (IMEM_BYTES),
    .PC_W       (PC_W),
    .AW         (AW)
  ) u_imem (
    .clk    (clk),
    .we     (bus.imem_we && (r_state == S_IDLE)),
    .waddr  (bus.imem_waddr),
    .wdata  (bus.imem_wdata),
    .rpc    (r_pc),
    .window (w_win)
  );

  // Instruction split and length/address arithmetic on the current window
  assign w_icode  = w_win[7:4];
  assign w_ifun   = w_win[3:0];
  assign w_regids = has_regids(w_icode);
  assign w_len    = ilen(w_icode);
  assign w_valc64 = w_regids ? w_win[79:16] : w_win[71:8];
  assign w_valp   = r_pc + PC_W'(w_len);
  assign w_end    = {1'b0, r_pc} + (PC_W+1)'(w_len);
  assign w_adr    = ({1'b0, r_pc} >= c_lim) || (w_end > c_lim);

  // Opcode/function legality check
  always_comb begin
    w_ins = 1'b0;
    if (w_icode > I_POPQ) begin
      w_ins = 1'b1;
    end else begin
      case (w_icode)
        I_RRMOVQ, I_JXX: w_ins = (w_ifun > 4'd6);
        I_OPQ:           w_ins = (w_ifun > 4'd3);
        default:         w_ins = (w_ifun != 4'd0);
      endcase
    end
  end

  // Address faults outrank illegal opcodes
  assign w_stat = w_adr                ? STAT_ADR :
                  w_ins                ? STAT_INS :
                  (w_icode == I_HALT)  ? STAT_HLT : STAT_AOK;

  // State and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next state, slot-load enable and next PC; a redirect beats valP
  always_comb begin
    w_state_nxt = r_state;
    w_load_slot = 1'b0;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (bus.pc_load) w_pc_nxt    = bus.pc_load_val;
        if (bus.start)   w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (!r_out_valid || bus.out_ready) begin
          w_load_slot = 1'b1;
          w_pc_nxt    = w_valp;
          if (w_stat != STAT_AOK)  w_state_nxt = S_HALTED;
          else if (is_ctrl(w_icode)) w_state_nxt = S_WAIT_PC;
        end
        if (bus.pc_load) w_pc_nxt = bus.pc_load_val;
      end
      S_WAIT_PC: begin
        if (bus.pc_load) begin
          w_pc_nxt    = bus.pc_load_val;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        // HALTED holds until reset
      end
    endcase
  end

  // Output slot: load a new instruction, or retire the held one on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= REG_NONE;
      r_rb        <= REG_NONE;
      r_valc      <= '0;
      r_valp      <= '0;
      r_pc_out    <= '0;
      r_stat      <= STAT_AOK;
    end else if (w_load_slot) begin
      r_out_valid <= 1'b1;
      r_icode     <= w_icode;
      r_ifun      <= w_ifun;
      r_ra        <= w_regids ? w_win[15:12] : REG_NONE;
      r_rb        <= w_regids ? w_win[11:8]  : REG_NONE;
      r_valc      <= PC_W'(w_valc64);
      r_valp      <= w_valp;
      r_pc_out    <= r_pc;
      r_stat      <= w_stat;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.icode     = r_icode;
  assign bus.ifun      = r_ifun;
  assign bus.rA        = r_ra;
  assign bus.rB        = r_rb;
  assign bus.valC      = r_valc;
  assign bus.valP      = r_valp;
  assign bus.pc_out    = r_pc_out;
  assign bus.stat      = r_stat;
  assign bus.state_o   = r_state;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count, r_stall_cycles;

  // Saturating handshake and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_out_valid && bus.out_ready && (r_fetch_count != '1))
        r_fetch_count <= r_fetch_count + 32'd1;
      if (((r_out_valid && !bus.out_ready) || (r_state == S_WAIT_PC)) &&
          (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_fetch_unit
// Description : Self-checking bench for y86_fetch_unit: a table of single
//               instruction vectors plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_fetch_unit;
  import y86_pkg::*;

  localparam int IMEM_BYTES = 256;
  localparam int PC_W       = 64;
  localparam int AW         = $clog2(IMEM_BYTES);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, stall_cycles;
`endif

  y86_fetch_unit_if #(.IMEM_BYTES(IMEM_BYTES), .PC_W(PC_W)) bus ();

  y86_fetch_unit #(
    .IMEM_BYTES (IMEM_BYTES),
    .PC_W       (PC_W),
    .RESET_PC   (64'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] addr;
    int          nb;
    logic [79:0] bytes;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    bit          chk_valc;
    logic [63:0] e_valc;
    logic [63:0] e_valp;
    logic [1:0]  e_stat;
    logic [1:0]  e_state;
    bit          chk_fields;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [63:0] addr, input int nb, input logic [79:0] bytes,
                              input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input bit cv, input logic [63:0] vc, input logic [63:0] vp,
                              input logic [1:0] st, input logic [1:0] fs, input bit cf);
    vec_t v;
    v.addr = addr; v.nb = nb; v.bytes = bytes;
    v.e_icode = ic; v.e_ifun = fn; v.e_ra = ra; v.e_rb = rb;
    v.chk_valc = cv; v.e_valc = vc; v.e_valp = vp;
    v.e_stat = st; v.e_state = fs; v.chk_fields = cf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; waits a bounded number of cycles for out_valid.
  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=out_valid=0 required=out_valid=1", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_we = 1'b0; bus.start = 1'b0; bus.pc_load = 1'b0;
    bus.pc_load_val = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_bytes(input logic [63:0] addr, input int nb, input logic [79:0] bytes);
    logic [79:0] b = bytes;
    for (int i = 0; i < nb; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = AW'(addr + 64'(i));
      bus.imem_wdata = b[8*i +: 8];
      @(negedge clk);
    end
    bus.imem_we = 1'b0;
  endtask

  task automatic go(input logic [63:0] pc);
    bus.pc_load = 1'b1; bus.pc_load_val = pc; bus.start = 1'b1;
    @(negedge clk);
    bus.pc_load = 1'b0; bus.start = 1'b0;
  endtask

  logic [63:0] q_pc[$], q_valp[$];
  logic [3:0]  q_ic[$], q_ra[$], q_rb[$];
  logic [1:0]  q_st[$];

  initial begin
    vec_t v;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    bus.start = 1'b0; bus.pc_load = 1'b0; bus.pc_load_val = '0; bus.out_ready = 1'b0;

    // ---- vector table: addr, nbytes, bytes(LE), icode, ifun, rA, rB, chkC, valC, valP, stat, state, chkF
    vecs.push_back(mk(64'h00, 10, 80'h0102030405060708F330, 4'h3, 4'h0, 4'hF, 4'h3, 1, 64'h0102030405060708, 64'd10,  2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h00,  9, 80'h00000000000000004070, 4'h7, 4'h0, 4'hF, 4'hF, 1, 64'h40,  64'd9,   2'd0, 2'd2, 1));
    vecs.push_back(mk(64'h20,  9, 80'h00000000000000010080, 4'h8, 4'h0, 4'hF, 4'hF, 1, 64'h100, 64'h29,  2'd0, 2'd2, 1));
    vecs.push_back(mk(64'h30,  1, 80'h90,                   4'h9, 4'h0, 4'hF, 4'hF, 0, 64'h0,   64'h31,  2'd0, 2'd2, 1));
    vecs.push_back(mk(64'h40, 10, 80'h11223344556677881250, 4'h5, 4'h0, 4'h1, 4'h2, 1, 64'h1122334455667788, 64'h4A, 2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h00,  2, 80'h1263,                 4'h6, 4'h3, 4'h1, 4'h2, 0, 64'h0,   64'd2,   2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h00,  2, 80'h1264,                 4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd3, 2'd3, 0));
    vecs.push_back(mk(64'h00,  1, 80'hC0,                   4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd3, 2'd3, 0));
    vecs.push_back(mk(64'h00,  2, 80'h1227,                 4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd3, 2'd3, 0));
    vecs.push_back(mk(64'h50,  1, 80'h00,                   4'h0, 4'h0, 4'hF, 4'hF, 0, 64'h0,   64'h51,  2'd1, 2'd3, 1));
    vecs.push_back(mk(64'd251, 5, 80'h0102030405060708F330, 4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd2, 2'd3, 0));
    vecs.push_back(mk(64'd246,10, 80'h0102030405060708F330, 4'h3, 4'h0, 4'hF, 4'h3, 1, 64'h0102030405060708, 64'd256, 2'd0, 2'd1, 1));
    vecs.push_back(mk(64'd256, 0, 80'h0,                    4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd2, 2'd3, 0));
    vecs.push_back(mk(64'h60,  2, 80'h3FA0,                 4'hA, 4'h0, 4'h3, 4'hF, 0, 64'h0,   64'h62,  2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h70,  1, 80'h10,                   4'h1, 4'h0, 4'hF, 4'hF, 0, 64'h0,   64'h71,  2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h80,  2, 80'h4561,                 4'h6, 4'h1, 4'h4, 4'h5, 0, 64'h0,   64'h82,  2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h90,  2, 80'h1225,                 4'h2, 4'h5, 4'h1, 4'h2, 0, 64'h0,   64'h92,  2'd0, 2'd1, 1));
    vecs.push_back(mk(64'h98,  1, 80'h11,                   4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd3, 2'd3, 0));
    vecs.push_back(mk(64'hA0,  9, 80'h00000000000000000876, 4'h7, 4'h6, 4'hF, 4'hF, 1, 64'h8,   64'hA9,  2'd0, 2'd2, 1));
    vecs.push_back(mk(64'hB0,  1, 80'h77,                   4'h0, 4'h0, 4'h0, 4'h0, 0, 64'h0,   64'h0,   2'd3, 2'd3, 0));

    // ---- reset state
    @(negedge clk);
    chk("rst_state",     64'(bus.state_o),   64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_icode",     64'(bus.icode),     64'h0);
    chk("rst_ifun",      64'(bus.ifun),      64'h0);
    chk("rst_rA",        64'(bus.rA),        64'hF);
    chk("rst_rB",        64'(bus.rB),        64'hF);
    chk("rst_valC",      bus.valC,           64'h0);
    chk("rst_valP",      bus.valP,           64'h0);
    chk("rst_pc_out",    bus.pc_out,         64'h0);
    chk("rst_stat",      64'(bus.stat),      64'd0);

    // ---- table-driven single-instruction vectors
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      do_reset();
      load_bytes(v.addr, v.nb, v.bytes);
      go(v.addr);
      wait_valid($sformatf("v%0d_valid", k));
      chk($sformatf("v%0d_pc_out", k), bus.pc_out,       v.addr);
      chk($sformatf("v%0d_stat", k),   64'(bus.stat),    64'(v.e_stat));
      chk($sformatf("v%0d_state", k),  64'(bus.state_o), 64'(v.e_state));
      if (v.chk_fields) begin
        chk($sformatf("v%0d_icode", k), 64'(bus.icode), 64'(v.e_icode));
        chk($sformatf("v%0d_ifun", k),  64'(bus.ifun),  64'(v.e_ifun));
        chk($sformatf("v%0d_rA", k),    64'(bus.rA),    64'(v.e_ra));
        chk($sformatf("v%0d_rB", k),    64'(bus.rB),    64'(v.e_rb));
        chk($sformatf("v%0d_valP", k),  bus.valP,       v.e_valp);
      end
      if (v.chk_valc)
        chk($sformatf("v%0d_valC", k), bus.valC, v.e_valc);
    end

    // ---- streaming program: nop; rrmovq %rsi,%rdx; halt
    do_reset();
    load_bytes(64'h0, 4, 80'h00622010);
    bus.out_ready = 1'b1;
    go(64'h0);
    q_pc.delete(); q_valp.delete(); q_ic.delete(); q_ra.delete(); q_rb.delete(); q_st.delete();
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) begin
        q_pc.push_back(bus.pc_out); q_valp.push_back(bus.valP); q_ic.push_back(bus.icode);
        q_ra.push_back(bus.rA); q_rb.push_back(bus.rB); q_st.push_back(bus.stat);
      end
      @(negedge clk);
    end
    chk("stream_count", 64'(q_pc.size()), 64'd3);
    if (q_pc.size() == 3) begin
      chk("stream0_icode", 64'(q_ic[0]), 64'h1);
      chk("stream0_valP",  q_valp[0],    64'd1);
      chk("stream1_icode", 64'(q_ic[1]), 64'h2);
      chk("stream1_rA",    64'(q_ra[1]), 64'h6);
      chk("stream1_rB",    64'(q_rb[1]), 64'h2);
      chk("stream1_valP",  q_valp[1],    64'd3);
      chk("stream2_pc",    q_pc[2],      64'd3);
      chk("stream2_stat",  64'(q_st[2]), 64'd1);
    end
    chk("stream_state_halted", 64'(bus.state_o),   64'd3);
    chk("stream_valid_drop",   64'(bus.out_valid), 64'd0);

    // ---- jmp, stall in WAIT_PC, redirect to target
    do_reset();
    load_bytes(64'h0, 9, 80'h00000000000000004070);
    load_bytes(64'h40, 1, 80'h10);
    bus.out_ready = 1'b1;
    go(64'h0);
    wait_valid("jmp_valid");
    chk("jmp_valC", bus.valC, 64'h40);
    repeat (3) @(negedge clk);
    chk("wait_no_slot", 64'(bus.out_valid), 64'd0);
    chk("wait_state",   64'(bus.state_o),   64'd2);
    bus.pc_load = 1'b1; bus.pc_load_val = 64'h40;
    @(negedge clk);
    bus.pc_load = 1'b0;
    chk("redir_state", 64'(bus.state_o), 64'd1);
    wait_valid("redir_valid");
    chk("redir_pc_out", bus.pc_out,       64'h40);
    chk("redir_icode",  64'(bus.icode),   64'h1);
    chk("redir_valP",   bus.valP,         64'h41);

    // ---- back-pressure: slot must hold while out_ready is low
    do_reset();
    load_bytes(64'h0, 3, 80'h101010);
    bus.out_ready = 1'b0;
    go(64'h0);
    wait_valid("stall_valid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall%0d_pc", c),    bus.pc_out,         64'h0);
      chk($sformatf("stall%0d_valP", c),  bus.valP,           64'd1);
    end
`ifdef FETCH_STATS_EN
    chk("stats_stall5",  64'(stall_cycles), 64'd5);
    chk("stats_fetch0",  64'(fetch_count),  64'd0);
`endif
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_pc", bus.pc_out, 64'd1);
`ifdef FETCH_STATS_EN
    chk("stats_fetch1", 64'(fetch_count), 64'd1);
`endif

    // ---- asynchronous reset while in WAIT_PC
    do_reset();
    load_bytes(64'h0, 9, 80'h00000000000000004070);
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid("arst_jmp_valid");
    repeat (2) @(negedge clk);
    chk("arst_pre_state", 64'(bus.state_o), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",     64'(bus.state_o),   64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_pc_out",    bus.pc_out,         64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid("arst_refetch_valid");
    chk("arst_refetch_pc",    bus.pc_out,     64'h0);
    chk("arst_refetch_icode", 64'(bus.icode), 64'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
